readout_event_sequencer: RTL and testbench
==========================================

// Module: readout_event_sequencer
// PURPOSE
//  Event-rate controller for the priority-encoded memory readout merger. Issues the
//  one-cycle new-event pulse every BX_PERIOD clocks and maintains BX, BX_pipe and clk_cnt.
//  Counts the valid words the merger emits and watches the merger's done flag.
//  Flags and counts events that the next new-event pulse truncates.
// PARAMETERS
//  BX_PERIOD  108  clocks per event slot; legal range 4..127
//  SETUP_CYC  3    clocks of merger holdoff after new_event, matching the merger's setup
//  WCNT_W     10   width of the per-event valid-word counter
//  TCNT_W     16   width of the saturating truncation counter
// PORTS
//  clk         in   1       processing clock
//  reset       in   1       synchronous, active-high
//  enable      in   1       run sequencing; 0 holds in IDLE after the current slot
//  mrg_valid   in   1       merger valid word
//  mrg_done    in   1       merger done (no more data)
//  new_event   out  1       1-cycle pulse to the merger reset/new-event input
//  BX          out  3       event number, mod 8
//  clk_cnt     out  7       clocks since the last new_event, 0..BX_PERIOD-1
//  BX_pipe     out  3       increments on each clk_cnt wrap
//  busy        out  1       slot in progress (SETUP or READOUT)
//  ev_words    out  WCNT_W  valid words in the last finished slot
//  ev_ok       out  1       1-cycle pulse: slot completed with mrg_done
//  truncated   out  1       1-cycle pulse: slot ended without mrg_done
//  trunc_cnt   out  TCNT_W  saturating count of truncated slots
// BEHAVIOUR
//  Reset state:
//   - State IDLE; every output is 0.
//   - reset during any state aborts it with no flag pulse and no counter update.
//  FSM: IDLE -> START -> SETUP -> READOUT -> (DONE | START)
//   - IDLE: enable=1 -> START next cycle.
//   - START: new_event=1 for exactly this cycle.
//       clk_cnt<=0; BX<=BX+1, except on the first START after IDLE, where BX is kept.
//       Word counter cleared. -> SETUP.
//   - SETUP: SETUP_CYC cycles. mrg_valid and mrg_done are ignored. -> READOUT.
//   - READOUT:
//       Word counter +1 per mrg_valid; saturates at all-ones.
//       mrg_done=1 -> DONE: ev_ok pulses, ev_words latched.
//       clk_cnt==BX_PERIOD-1 with no done -> truncated pulses, trunc_cnt+1 (saturating),
//         ev_words latched. Then START if enable, else IDLE.
//       Done and wrap in the same cycle count as a completion: ev_ok, not truncated.
//   - DONE: wait for the wrap. At wrap: enable -> START, else -> IDLE.
//  clk_cnt:
//   - Increments every cycle outside IDLE; wraps BX_PERIOD-1 -> 0.
//   - The wrap cycle is the cycle before START, so new_event period = BX_PERIOD exactly.
//  BX_pipe: +1 when clk_cnt wraps; mod 8.
//  busy: 1 in SETUP and READOUT; 0 in IDLE, START and DONE.
//  Deasserting enable mid-slot does not cut the slot; the slot finishes normally.
//  Outputs are registered, with no combinational input-to-output paths.
//  A mrg_valid in the same cycle as the wrap is counted into that slot's ev_words.
// STRUCTURE
//  Shared package readout_pkg holds:
//   - State enum: IDLE, START, SETUP, READOUT, DONE.
//   - Constants BX_PERIOD_DEF=108, SETUP_CYC_DEF=3.
//  One sub-module: sat_counter (parameterised width, clear, increment, saturate).
//   Used for the word counter and trunc_cnt.
//  The FSM and clk_cnt/BX counters stay in the top module.
// TESTING
//  1. reset, then enable=1 from cycle 0:
//     new_event pulses at cycles 1, 109, 217. BX reads 0, 1, 2 after each pulse.
//  2. Per slot, 5 mrg_valid during READOUT, then mrg_done at clk_cnt=20:
//     ev_ok pulses; ev_words=5; truncated=0; busy drops.
//  3. No mrg_done in a slot: truncated pulses at clk_cnt wrap. trunc_cnt=1; ev_words latched.
//  4. mrg_done exactly at clk_cnt=107: ev_ok=1, truncated=0.
//  5. mrg_valid during SETUP: not counted. enable dropped mid-slot: slot completes, then IDLE.
//  6. reset at clk_cnt=50 of READOUT: all outputs 0 next cycle, no flag pulse.
//     Force trunc_cnt near max: it saturates at 16'hFFFF.

Source files
------------

// File: rtl/readout_pkg.sv
// rtl/readout_pkg.sv - shared types and constants for the readout event sequencer
package readout_pkg;

  // Sequencer slot phases
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    SETUP   = 3'd2,
    READOUT = 3'd3,
    DONE    = 3'd4
  } seq_state_e;

  localparam int BX_PERIOD_DEF = 108;
  localparam int SETUP_CYC_DEF = 3;

  // clk_cnt covers BX_PERIOD up to 127; BX and BX_pipe are mod 8
  localparam int CLK_CNT_W = 7;
  localparam int BX_W      = 3;

endpackage

// File: rtl/readout_event_sequencer_if.sv
// rtl/readout_event_sequencer_if.sv - control, merger handshake and status bundle
interface readout_event_sequencer_if #(
  parameter int WCNT_W = 10,
  parameter int TCNT_W = 16
) ();
  import readout_pkg::*;

  logic                 enable;
  logic                 mrg_valid;
  logic                 mrg_done;
  logic                 new_event;
  logic [BX_W-1:0]      BX;
  logic [CLK_CNT_W-1:0] clk_cnt;
  logic [BX_W-1:0]      BX_pipe;
  logic                 busy;
  logic [WCNT_W-1:0]    ev_words;
  logic                 ev_ok;
  logic                 truncated;
  logic [TCNT_W-1:0]    trunc_cnt;

  // Sequencer side: drives the event pulse and status
  modport master (
    input  enable, mrg_valid, mrg_done,
    output new_event, BX, clk_cnt, BX_pipe, busy,
           ev_words, ev_ok, truncated, trunc_cnt
  );

  // Host/merger side: drives enable and the merger outputs
  modport slave (
    output enable, mrg_valid, mrg_done,
    input  new_event, BX, clk_cnt, BX_pipe, busy,
           ev_words, ev_ok, truncated, trunc_cnt
  );

endinterface

// File: rtl/readout_event_sequencer_sat_counter.sv
// rtl/readout_event_sequencer_sat_counter.sv - saturating up-counter with clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_nxt_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // count_nxt_o ignores clr so a caller can capture the final value in the
  // same cycle the counter is being cleared for the next slot
  always_comb begin
    count_nxt_o = count_q;
    if (inc_i && (count_q != '1)) begin
      count_nxt_o = count_q + W'(1);
    end
    count_d = clr_i ? '0 : count_nxt_o;
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/readout_event_sequencer.sv
// rtl/readout_event_sequencer.sv - new-event pacing and slot bookkeeping for the readout merger
module readout_event_sequencer
  import readout_pkg::*;
#(
  parameter int BX_PERIOD = BX_PERIOD_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int WCNT_W    = 10,
  parameter int TCNT_W    = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  readout_event_sequencer_if.master  seq_if
);

  localparam logic [CLK_CNT_W-1:0] LAST_CNT  = CLK_CNT_W'(BX_PERIOD - 1);
  localparam logic [CLK_CNT_W-1:0] SETUP_END = CLK_CNT_W'(SETUP_CYC);

  seq_state_e           state_q, state_d;
  logic [CLK_CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [BX_W-1:0]      bx_q, bx_d;
  logic [BX_W-1:0]      bx_pipe_q, bx_pipe_d;
  logic                 new_event_q, new_event_d;
  logic                 busy_q, busy_d;
  logic                 ev_ok_q, ev_ok_d;
  logic                 truncated_q, truncated_d;
  logic [WCNT_W-1:0]    ev_words_q, ev_words_d;

  logic                 wrap;
  logic                 slot_ok;
  logic                 slot_trunc;
  logic                 word_clr;
  logic                 word_inc;
  logic [WCNT_W-1:0]    word_cnt_unused;
  logic [WCNT_W-1:0]    word_nxt;
  logic [TCNT_W-1:0]    trunc_cnt;
  logic [TCNT_W-1:0]    trunc_nxt_unused;

  // Slot-end conditions; the wrap cycle is the last cycle of a slot
  always_comb begin
    wrap       = (state_q != IDLE) && (clk_cnt_q == LAST_CNT);
    slot_ok    = (state_q == READOUT) && seq_if.mrg_done;
    slot_trunc = wrap && ((state_q == SETUP) ||
                          ((state_q == READOUT) && !seq_if.mrg_done));
    word_inc   = (state_q == READOUT) && seq_if.mrg_valid;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (seq_if.enable) state_d = START;
      end
      START: begin
        state_d = SETUP;
      end
      SETUP: begin
        // Only reachable with a very short BX_PERIOD: slot ends before readout
        if (wrap)                        state_d = seq_if.enable ? START : IDLE;
        else if (clk_cnt_q == SETUP_END) state_d = READOUT;
      end
      READOUT: begin
        if (wrap)                 state_d = seq_if.enable ? START : IDLE;
        else if (seq_if.mrg_done) state_d = DONE;
      end
      DONE: begin
        if (wrap) state_d = seq_if.enable ? START : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and counter next values, all derived from state_d so outputs stay registered
  always_comb begin
    word_clr    = (state_d == START);
    new_event_d = (state_d == START);
    busy_d      = (state_d == SETUP) || (state_d == READOUT);
    ev_ok_d     = slot_ok;
    truncated_d = slot_trunc;

    clk_cnt_d = clk_cnt_q + CLK_CNT_W'(1);
    if ((state_d == START) || (state_d == IDLE)) begin
      clk_cnt_d = '0;
    end

    // The first START after IDLE reuses the held BX
    bx_d = bx_q;
    if ((state_d == START) && (state_q != IDLE)) begin
      bx_d = bx_q + BX_W'(1);
    end

    bx_pipe_d = bx_pipe_q;
    if (wrap) begin
      bx_pipe_d = bx_pipe_q + BX_W'(1);
    end

    // word_nxt already includes a valid word arriving on the final cycle
    ev_words_d = ev_words_q;
    if (slot_ok || slot_trunc) begin
      ev_words_d = word_nxt;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered outputs and slot counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      clk_cnt_q   <= '0;
      bx_q        <= '0;
      bx_pipe_q   <= '0;
      new_event_q <= 1'b0;
      busy_q      <= 1'b0;
      ev_ok_q     <= 1'b0;
      truncated_q <= 1'b0;
      ev_words_q  <= '0;
    end else begin
      clk_cnt_q   <= clk_cnt_d;
      bx_q        <= bx_d;
      bx_pipe_q   <= bx_pipe_d;
      new_event_q <= new_event_d;
      busy_q      <= busy_d;
      ev_ok_q     <= ev_ok_d;
      truncated_q <= truncated_d;
      ev_words_q  <= ev_words_d;
    end
  end

  sat_counter #(.W(WCNT_W)) u_word_cnt (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clr_i       (word_clr),
    .inc_i       (word_inc),
    .count_o     (word_cnt_unused),
    .count_nxt_o (word_nxt)
  );

  sat_counter #(.W(TCNT_W)) u_trunc_cnt (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .clr_i       (1'b0),
    .inc_i       (slot_trunc),
    .count_o     (trunc_cnt),
    .count_nxt_o (trunc_nxt_unused)
  );

  assign seq_if.new_event = new_event_q;
  assign seq_if.BX        = bx_q;
  assign seq_if.clk_cnt   = clk_cnt_q;
  assign seq_if.BX_pipe   = bx_pipe_q;
  assign seq_if.busy      = busy_q;
  assign seq_if.ev_words  = ev_words_q;
  assign seq_if.ev_ok     = ev_ok_q;
  assign seq_if.truncated = truncated_q;
  assign seq_if.trunc_cnt = trunc_cnt;

endmodule

// File: tb/tb_readout_event_sequencer.sv
// tb/tb_readout_event_sequencer.sv - directed bench for readout_event_sequencer
module tb_readout_event_sequencer;

  logic clk;
  logic reset;
  int   cyc;
  int   n_assert;
  int   n_fail;

  readout_event_sequencer_if #(.WCNT_W(10), .TCNT_W(16)) m_if ();
  readout_event_sequencer_if #(.WCNT_W(2),  .TCNT_W(2))  s_if ();

  readout_event_sequencer #(
    .BX_PERIOD (108),
    .SETUP_CYC (3),
    .WCNT_W    (10),
    .TCNT_W    (16)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .seq_if  (m_if.master)
  );

  // Short slots and narrow counters so saturation is reachable quickly
  readout_event_sequencer #(
    .BX_PERIOD (8),
    .SETUP_CYC (3),
    .WCNT_W    (2),
    .TCNT_W    (2)
  ) dut_small (
    .clk_i   (clk),
    .reset_i (reset),
    .seq_if  (s_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_main(input string tag, input int ne, input int bx, input int cc,
                          input int bxp, input int bsy, input int words, input int ok,
                          input int tr, input int tcnt);
    chk({tag, ".new_event"}, 32'(m_if.new_event), 32'(ne));
    chk({tag, ".BX"},        32'(m_if.BX),        32'(bx));
    chk({tag, ".clk_cnt"},   32'(m_if.clk_cnt),   32'(cc));
    chk({tag, ".BX_pipe"},   32'(m_if.BX_pipe),   32'(bxp));
    chk({tag, ".busy"},      32'(m_if.busy),      32'(bsy));
    chk({tag, ".ev_words"},  32'(m_if.ev_words),  32'(words));
    chk({tag, ".ev_ok"},     32'(m_if.ev_ok),     32'(ok));
    chk({tag, ".truncated"}, 32'(m_if.truncated), 32'(tr));
    chk({tag, ".trunc_cnt"}, 32'(m_if.trunc_cnt), 32'(tcnt));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    reset    = 1'b1;
    m_if.enable = 1'b0; m_if.mrg_valid = 1'b0; m_if.mrg_done = 1'b0;
    s_if.enable = 1'b0; s_if.mrg_valid = 1'b0; s_if.mrg_done = 1'b0;
    repeat (3) tick();
    chk_main("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Cycle 0: reset released, enable high
    reset = 1'b0;
    cyc   = 0;
    m_if.enable = 1'b1;
    s_if.enable = 1'b1;
    s_if.mrg_valid = 1'b1;
    chk_main("cyc0", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tick();
    chk_main("cyc1_start", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk_main("cyc2_setup", 0, 0, 1, 0, 1, 0, 0, 0, 0);

    // Valid during SETUP must be ignored
    go_to(3);  m_if.mrg_valid = 1'b1;
    go_to(4);  m_if.mrg_valid = 1'b0;

    // Small instance: first truncation, word count saturated at 3
    go_to(9);
    chk("small.new_event", 32'(s_if.new_event), 32'd1);
    chk("small.BX",        32'(s_if.BX),        32'd1);
    chk("small.truncated", 32'(s_if.truncated), 32'd1);
    chk("small.ev_words",  32'(s_if.ev_words),  32'd3);
    chk("small.trunc1",    32'(s_if.trunc_cnt), 32'd1);

    // Five words in READOUT
    go_to(10); m_if.mrg_valid = 1'b1;
    go_to(15); m_if.mrg_valid = 1'b0;

    go_to(17);
    chk("small.trunc2", 32'(s_if.trunc_cnt), 32'd2);

    go_to(21);
    chk("slot1.busy_before_done", 32'(m_if.busy), 32'd1);
    chk("slot1.clk_cnt20",        32'(m_if.clk_cnt), 32'd20);
    m_if.mrg_done = 1'b1;
    go_to(22);
    m_if.mrg_done = 1'b0;
    chk_main("slot1_done", 0, 0, 21, 0, 0, 5, 1, 0, 0);
    go_to(23);
    chk("slot1.ev_ok_pulse_end", 32'(m_if.ev_ok), 32'd0);

    go_to(25);
    chk("small.trunc3", 32'(s_if.trunc_cnt), 32'd3);
    go_to(41);
    chk("small.truncated_sat", 32'(s_if.truncated), 32'd1);
    chk("small.trunc_sat",     32'(s_if.trunc_cnt), 32'd3);

    go_to(108);
    chk("slot1.clk_cnt_last", 32'(m_if.clk_cnt), 32'd107);
    chk("slot1.no_pulse",     32'(m_if.new_event), 32'd0);

    // Slot 2: no done; last word arrives on the wrap cycle
    go_to(109);
    chk_main("slot2_start", 1, 1, 0, 1, 0, 5, 0, 0, 0);
    go_to(112); m_if.mrg_valid = 1'b1;
    go_to(113); m_if.mrg_valid = 1'b0;
    go_to(139); m_if.mrg_valid = 1'b1;
    go_to(142); m_if.mrg_valid = 1'b0;
    go_to(216); m_if.mrg_valid = 1'b1;
    go_to(217); m_if.mrg_valid = 1'b0;
    chk_main("slot2_trunc", 1, 2, 0, 2, 0, 4, 0, 1, 1);
    go_to(218);
    chk("slot2.trunc_pulse_end", 32'(m_if.truncated), 32'd0);
    chk("slot2.trunc_cnt_hold",  32'(m_if.trunc_cnt), 32'd1);

    // Slot 3: enable dropped mid-slot, done on the wrap cycle
    go_to(250); m_if.enable = 1'b0;
    go_to(267); m_if.mrg_valid = 1'b1;
    go_to(269); m_if.mrg_valid = 1'b0;
    go_to(324); m_if.mrg_done = 1'b1;
    go_to(325); m_if.mrg_done = 1'b0;
    chk_main("slot3_edge_done", 0, 2, 0, 3, 0, 2, 1, 0, 1);
    go_to(326);
    chk("idle.new_event", 32'(m_if.new_event), 32'd0);
    chk("idle.ev_ok",     32'(m_if.ev_ok),     32'd0);
    chk("idle.clk_cnt",   32'(m_if.clk_cnt),   32'd0);
    m_if.enable = 1'b1;

    // Restart from IDLE keeps BX
    go_to(327);
    chk_main("restart", 1, 2, 0, 3, 0, 2, 0, 0, 1);

    // Reset in READOUT with a done pending: no pulse, everything cleared
    go_to(377);
    chk("slot4.clk_cnt50", 32'(m_if.clk_cnt), 32'd50);
    chk("slot4.busy",      32'(m_if.busy),    32'd1);
    reset = 1'b1;
    m_if.mrg_done = 1'b1;
    go_to(378);
    chk_main("reset_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    m_if.mrg_done = 1'b0;
    m_if.enable = 1'b0;
    go_to(379);
    chk_main("after_reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
